// File: rtl/posit_div_seq.sv
// Sequential posit divider: decode, restoring mantissa divide, then rounded re-encode.
// Fixed latency for every operand pair, special cases included. es must be at least 1.
module posit_div_seq #(
   parameter int N  = 8,
   parameter int es = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   output logic [N-1:0] out,
   output logic         inf,
   output logic         zero,
   output logic         done,
   output logic         busy
);

   localparam int M  = N - es - 2;
   localparam int SW = $clog2(N) + es + 3;
   localparam int T  = es + M + 1;
   localparam int VW = N + T;
   localparam int CW = $clog2(M + 2) + 1;

   typedef enum logic [2:0] {IDLE, DECODE, DIV, ENC, DONE} stateT;

   typedef struct packed {
      logic                 sign;
      logic signed [SW-1:0] scale;
      logic [M-1:0]         mant;
   } decT;

   stateT state, nextState;

   logic [N-1:0]         opA, opB;
   logic                 sgn, narF, zeroF;
   logic signed [SW-1:0] scale;
   logic [M:0]           rem;
   logic [M-1:0]         dvs;
   logic [M+1:0]         quo;
   logic [CW-1:0]        cnt;

   decT                  decA, decB;
   logic                 qBit;
   logic [M:0]           remSub;
   logic [N-1:0]         encOut;

   // Splits one posit into sign, combined scale k*2^es+e and hidden-bit mantissa.
   function automatic decT decodePosit(input logic [N-1:0] x);
      decT                  d;
      logic [N-2:0]         body;
      logic [es-1:0]        e;
      logic [M-2:0]         f;
      logic signed [SW-1:0] kv;
      logic                 regBit, stop;
      int                   run;
      body   = x[N-1] ? (N-1)'(-x) : x[N-2:0];
      regBit = body[N-2];
      run    = 0;
      stop   = 1'b0;
      for (int i = N - 2; i >= 0; i--) begin
         if (!stop && body[i] == regBit) run++;
         else stop = 1'b1;
      end
      {e, f}  = (N-3)'((body << (run + 1)) >> 2);
      kv      = regBit ? SW'(run - 1) : SW'(-run);
      d.sign  = x[N-1];
      d.scale = (kv <<< es) + $signed({{(SW-es){1'b0}}, e});
      d.mant  = {1'b1, f};
      return d;
   endfunction

   function automatic logic isNaR(input logic [N-1:0] x);
      return x == {1'b1, {(N-1){1'b0}}};
   endfunction

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:    if (start) nextState = DECODE;
         DECODE:  nextState = DIV;
         DIV:     if (cnt == CW'(M + 1)) nextState = ENC;
         ENC:     nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      decA   = decodePosit(opA);
      decB   = decodePosit(opB);
      qBit   = (rem >= {1'b0, dvs});
      remSub = qBit ? (rem - {1'b0, dvs}) : rem;
   end

   // Encode: normalise quotient, build regime/exponent/fraction, round-nearest-even, saturate.
   logic signed [SW-1:0] sc, kS;
   logic [es-1:0]        eS;
   logic [M:0]           frac;
   logic [T-1:0]         tail;
   logic [N-1:0]         regVec, mag;
   logic [VW-1:0]        v;
   logic [N-2:0]         bodyE, magBody;
   logic                 guard, restOr, rUp, sticky;
   int                   kInt, r;

   always_comb begin
      sticky = |rem;
      sc     = quo[M+1] ? scale : (scale - SW'(1));
      frac   = quo[M+1] ? quo[M:0] : {quo[M-1:0], 1'b0};
      kS     = sc >>> es;
      eS     = sc[es-1:0];
      kInt   = int'(kS);
      tail   = {eS, frac};
      r      = (kInt >= 0) ? (kInt + 1) : -kInt;
      if (kInt >= 0) regVec = ~({N{1'b1}} >> r);
      else           regVec = N'(1) << (N - 1 - r);
      v       = {regVec, {T{1'b0}}} | ({{N{1'b0}}, tail} << (N - 1 - r));
      bodyE   = v[VW-1 -: N-1];
      guard   = v[VW-N];
      restOr  = (|v[VW-N-1:0]) | sticky;
      rUp     = guard & (restOr | bodyE[0]);
      magBody = bodyE + (N-1)'(rUp);
      if (kInt > N - 3)         mag = {1'b0, {(N-1){1'b1}}};
      else if (kInt < -(N - 2)) mag = N'(1);
      else                      mag = {1'b0, magBody};
      if (narF)       encOut = {1'b1, {(N-1){1'b0}}};
      else if (zeroF) encOut = '0;
      else            encOut = sgn ? -mag : mag;
   end

   // Datapath registers, each stage only touching its own state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA   <= '0;
         opB   <= '0;
         sgn   <= 1'b0;
         narF  <= 1'b0;
         zeroF <= 1'b0;
         scale <= '0;
         rem   <= '0;
         dvs   <= '0;
         quo   <= '0;
         cnt   <= '0;
         out   <= '0;
         inf   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  opA <= in1;
                  opB <= in2;
               end
            end
            DECODE: begin
               sgn   <= decA.sign ^ decB.sign;
               narF  <= isNaR(opA) | isNaR(opB) | (opB == '0);
               zeroF <= (opA == '0);
               scale <= decA.scale - decB.scale;
               rem   <= {1'b0, decA.mant};
               dvs   <= decB.mant;
               quo   <= '0;
               cnt   <= '0;
            end
            DIV: begin
               quo <= {quo[M:0], qBit};
               rem <= remSub << 1;
               cnt <= cnt + 1'b1;
            end
            ENC: begin
               out  <= encOut;
               inf  <= narF;
               zero <= ~narF & zeroF;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_posit_div_seq.sv
// Directed bench for posit_div_seq (N=8, es=1) with an expected-result queue.
module tb_posit_div_seq;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] in1   = 8'h00;
   logic [7:0] in2   = 8'h00;
   logic [7:0] out;
   logic       inf, zero, done, busy;

   typedef struct {
      logic [7:0] o;
      logic       i;
      logic       z;
   } expT;

   expT expQ[$];
   int  cmpCnt  = 0;
   int  failCnt = 0;

   always #5 clk = ~clk;

   posit_div_seq #(.N(8), .es(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
      .out(out), .inf(inf), .zero(zero), .done(done), .busy(busy)
   );

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      cmpCnt++;
      assert (obs === expv) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One-cycle start pulse (or held start) with the expected result queued.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eo,
                                input logic ei, input logic ez, input logic holdStart);
      expT e;
      @(negedge clk);
      in1   = a;
      in2   = b;
      start = 1'b1;
      e.o = eo; e.i = ei; e.z = ez;
      expQ.push_back(e);
      @(negedge clk);
      if (!holdStart) start = 1'b0;
   endtask

   // Entered one negedge after the capture edge; done is due at the 10th negedge.
   task automatic checkOutput(input string tag);
      int   cyc, busyCnt;
      logic got;
      expT  e;
      cyc = 1; busyCnt = 0; got = 1'b0;
      while (1) begin
         if (busy === 1'b1) busyCnt++;
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         if (cyc >= 30) break;
         @(negedge clk);
         cyc++;
      end
      checkVal({tag, ".doneSeen"}, 32'(got), 32'd1);
      if (expQ.size() > 0) e = expQ.pop_front();
      else begin
         e.o = 'x; e.i = 'x; e.z = 'x;
      end
      checkVal({tag, ".out"}, 32'(out), 32'(e.o));
      checkVal({tag, ".inf"}, 32'(inf), 32'(e.i));
      checkVal({tag, ".zero"}, 32'(zero), 32'(e.z));
      checkVal({tag, ".latency"}, 32'(cyc), 32'd10);
      checkVal({tag, ".busyCycles"}, 32'(busyCnt), 32'd10);
      @(negedge clk);
      checkVal({tag, ".busyAfter"}, 32'(busy), 32'd0);
      checkVal({tag, ".donePulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int doneCnt;
      #1;
      checkVal("reset.out", 32'(out), 32'h0);
      checkVal("reset.inf", 32'(inf), 32'h0);
      checkVal("reset.zero", 32'(zero), 32'h0);
      checkVal("reset.done", 32'(done), 32'h0);
      checkVal("reset.busy", 32'(busy), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(8'h40, 8'h50, 8'h30, 1'b0, 1'b0, 1'b0);
      checkOutput("basic");
      applyStimulus(8'h60, 8'hC0, 8'hA0, 1'b0, 1'b0, 1'b0);
      checkOutput("signedNeg");
      applyStimulus(8'hC0, 8'hC0, 8'h40, 1'b0, 1'b0, 1'b0);
      checkOutput("signedPos");
      applyStimulus(8'h40, 8'h58, 8'h25, 1'b0, 1'b0, 1'b0);
      checkOutput("oneThird");
      applyStimulus(8'h7F, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0);
      checkOutput("satMax");
      applyStimulus(8'h01, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      checkOutput("satMin");
      applyStimulus(8'h00, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
      checkOutput("zeroDividend");
      applyStimulus(8'h40, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0);
      checkOutput("divByZero");
      applyStimulus(8'h80, 8'h40, 8'h80, 1'b1, 1'b0, 1'b0);
      checkOutput("narDividend");

      // Abort in the 4th DIV cycle; out/inf were left non-zero by the NaR result.
      applyStimulus(8'h7F, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkVal("abort.out", 32'(out), 32'h0);
      checkVal("abort.inf", 32'(inf), 32'h0);
      checkVal("abort.zero", 32'(zero), 32'h0);
      checkVal("abort.done", 32'(done), 32'h0);
      checkVal("abort.busy", 32'(busy), 32'h0);
      void'(expQ.pop_front());
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      doneCnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done === 1'b1) doneCnt++;
      end
      checkVal("abort.noDone", 32'(doneCnt), 32'd0);
      applyStimulus(8'h50, 8'h40, 8'h50, 1'b0, 1'b0, 1'b0);
      checkOutput("afterAbort");

      // start held through busy and DONE with new operands after capture.
      applyStimulus(8'h40, 8'h50, 8'h30, 1'b0, 1'b0, 1'b1);
      begin
         expT e2;
         in1 = 8'h40;
         in2 = 8'hC0;
         e2.o = 8'hC0; e2.i = 1'b0; e2.z = 1'b0;
         expQ.push_back(e2);
      end
      checkOutput("overlapFirst");
      @(negedge clk);
      start = 1'b0;
      checkOutput("overlapSecond");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
      $finish;
   end

endmodule
